// File: rtl/counter_x.sv
// -----------------------------------------------------------------------------
// counter_x : three-channel, 8253-style programmable down-counter on the MIO bus
//
// Each channel counts down on rising edges of its own slow tick input and drives
// one output. counter0_OUT is the CPU interrupt source.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   rstn          asynchronous active-low reset
//   clk0..clk2    tick sources (divider taps). These are level signals that
//                 are edge-detected here and never used as clocks.
//   counter_we    write strobe, one clk cycle per write
//   counter_val   write data
//   counter_ch    channel select: 0..2 = counter n, 3 = control word
//   counter0_OUT  channel 0 output (interrupt source)
//   counter1_OUT  channel 1 output
//   counter2_OUT  channel 2 output
//   counter_out   readback: count of the selected channel, or the control word
//                 zero-extended when counter_ch = 3
//
// Write handshake: counter_we is a strobe with no back-pressure. Every cycle in
// which counter_we=1 is one accepted write of counter_val to the target named
// by counter_ch. The result is visible on counter_out on the next cycle.
//
// Control word: bits [2n+1:2n] select the mode of channel n.
//   00 one-shot, 01 rate generator, 10 square wave, 11 halt.
//
// Optional feature macro: COUNTER_X_SYNC_EN
//   defined   : clkN -> 2-flop synchronizer -> edge flop. The tick comes 2
//               cycles later than without it.
//   undefined : single edge flop. clkN is assumed synchronous to clk.
// -----------------------------------------------------------------------------
module counter_x #(
  parameter int         CNT_W    = 32,
  parameter logic [1:0] RST_MODE = 2'b00
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk0,
  input  logic             clk1,
  input  logic             clk2,
  input  logic             counter_we,
  input  logic [CNT_W-1:0] counter_val,
  input  logic [1:0]       counter_ch,
  output logic             counter0_OUT,
  output logic             counter1_OUT,
  output logic             counter2_OUT,
  output logic [CNT_W-1:0] counter_out
);

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RATE    = 2'b01;
  localparam logic [1:0] MODE_SQUARE  = 2'b10;
  localparam logic [1:0] MODE_HALT    = 2'b11;

  logic [2:0]       clk_in;
  logic [2:0]       edge_q;
  logic [2:0]       tick;
  logic [2:0]       wr_cnt;
  logic             wr_ctl;
  logic [5:0]       ctrl_q;
  logic [2:0]       out_q;
  logic [CNT_W-1:0] count_q  [3];
  logic [CNT_W-1:0] reload_q [3];

  assign clk_in = {clk2, clk1, clk0};

  // ---------------------------------------------------------------------------
  // Tick detection: one clk-cycle pulse per rising edge of clkN.
  // ---------------------------------------------------------------------------
`ifdef COUNTER_X_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~edge_q;
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_q <= '0;
    end else begin
      edge_q <= clk_in;
    end
  end

  assign tick = clk_in & ~edge_q;
`endif

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_cnt = '0;
    wr_ctl = 1'b0;
    if (counter_we) begin
      if (counter_ch == 2'b11) begin
        wr_ctl = 1'b1;
      end else begin
        wr_cnt[counter_ch] = 1'b1;
      end
    end
  end

  // Control register. A tick arriving in the same cycle as a control write
  // is still evaluated against the old ctrl_q, because the channel logic
  // below reads the registered value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q <= {RST_MODE, RST_MODE, RST_MODE};
    end else if (wr_ctl) begin
      ctrl_q <= counter_val[5:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Channel datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
      for (int n = 0; n < 3; n++) begin
        count_q[n]  <= '0;
        reload_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (wr_cnt[n]) begin
          // A write beats a coincident tick, and the tick is lost.
          reload_q[n] <= counter_val;
          count_q[n]  <= counter_val;
          out_q[n]    <= 1'b0;
        end else begin
          // The rate-generator pulse lasts one cycle. It clears here unless a
          // terminal tick below sets it again.
          if (ctrl_q[2*n +: 2] == MODE_RATE) begin
            out_q[n] <= 1'b0;
          end
          if (tick[n] && (ctrl_q[2*n +: 2] != MODE_HALT)) begin
            if (count_q[n] != '0) begin
              count_q[n] <= count_q[n] - CNT_W'(1);
            end else begin
              case (ctrl_q[2*n +: 2])
                MODE_ONESHOT: out_q[n] <= 1'b1;
                MODE_RATE: begin
                  count_q[n] <= reload_q[n];
                  out_q[n]   <= 1'b1;
                end
                MODE_SQUARE: begin
                  count_q[n] <= reload_q[n];
                  out_q[n]   <= ~out_q[n];
                end
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  assign counter0_OUT = out_q[0];
  assign counter1_OUT = out_q[1];
  assign counter2_OUT = out_q[2];

  // ---------------------------------------------------------------------------
  // Readback (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    counter_out = '0;
    case (counter_ch)
      2'b00:   counter_out = count_q[0];
      2'b01:   counter_out = count_q[1];
      2'b10:   counter_out = count_q[2];
      default: counter_out = {{(CNT_W-6){1'b0}}, ctrl_q};
    endcase
  end

endmodule

// File: tb/tb_counter_x.sv
// -----------------------------------------------------------------------------
// tb_counter_x : directed bench for counter_x
// -----------------------------------------------------------------------------
module tb_counter_x;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rstn;
  logic         clk0, clk1, clk2;
  logic         counter_we;
  logic [W-1:0] counter_val;
  logic [1:0]   counter_ch;
  logic         counter0_OUT, counter1_OUT, counter2_OUT;
  logic [W-1:0] counter_out;

  always #5 clk = ~clk;

  counter_x #(.CNT_W(W), .RST_MODE(2'b00)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clk0         (clk0),
    .clk1         (clk1),
    .clk2         (clk2),
    .counter_we   (counter_we),
    .counter_val  (counter_val),
    .counter_ch   (counter_ch),
    .counter0_OUT (counter0_OUT),
    .counter1_OUT (counter1_OUT),
    .counter2_OUT (counter2_OUT),
    .counter_out  (counter_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [1:0] ch, input logic [W-1:0] val);
    @(negedge clk);
    counter_we  = 1'b1;
    counter_ch  = ch;
    counter_val = val;
    @(negedge clk);
    counter_we  = 1'b0;
  endtask

  task automatic set_tick_src(input int n, input logic v);
    case (n)
      0:       clk0 = v;
      1:       clk1 = v;
      default: clk2 = v;
    endcase
  endtask

  function automatic logic out_of(input int n);
    case (n)
      0:       return counter0_OUT;
      1:       return counter1_OUT;
      default: return counter2_OUT;
    endcase
  endfunction

  // One rising edge on clkN, plus enough cycles for either tick latency.
  // hi returns how many negedge samples saw OUTn high in the window.
  task automatic tick(input int n, output int hi);
    hi = 0;
    @(negedge clk);
    set_tick_src(n, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_of(n)) hi++;
    end
    set_tick_src(n, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] ch, output logic [W-1:0] v);
    counter_ch = ch;
    #1;
    v = counter_out;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [W-1:0] v;
  int           hi;
  int           exp_rate_cnt [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    rstn = 1'b0; clk0 = 1'b0; clk1 = 1'b0; clk2 = 1'b0;
    counter_we = 1'b0; counter_val = '0; counter_ch = 2'b00;

    // Reset: activity while held in reset must have no effect.
    repeat (2) @(negedge clk);
    clk0 = 1'b1; clk1 = 1'b1; clk2 = 1'b1;
    counter_we = 1'b1; counter_ch = 2'b00; counter_val = 32'h55;
    repeat (2) @(negedge clk);
    counter_we = 1'b0;
    clk0 = 1'b0; clk1 = 1'b0; clk2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out0", {31'b0, counter0_OUT}, 0);
    check("rst_out1", {31'b0, counter1_OUT}, 0);
    check("rst_out2", {31'b0, counter2_OUT}, 0);
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), v);
      check($sformatf("rst_rd_ch%0d", c), v, 0);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'b00, v); check("post_rst_cnt0", v, 0);

    // One-shot, channel 0, reload 3.
    wr(2'b00, 32'd3);
    rd(2'b00, v); check("os_load", v, 3);
    for (int i = 1; i <= 7; i++) begin
      tick(0, hi);
      rd(2'b00, v);
      check($sformatf("os_cnt_t%0d", i), v, (i < 3) ? W'(3 - i) : W'(0));
      check($sformatf("os_out_t%0d", i), {31'b0, counter0_OUT}, (i >= 4) ? 1 : 0);
    end

    // Rate generator, channel 1, reload 2.
    wr(2'b11, 32'h04);
    rd(2'b11, v); check("rate_ctrl_rd", v, 32'h04);
    wr(2'b01, 32'd2);
    for (int i = 1; i <= 9; i++) begin
      tick(1, hi);
      rd(2'b01, v);
      check($sformatf("rate_cnt_t%0d", i), v, W'(exp_rate_cnt[i-1]));
      check($sformatf("rate_pulse_t%0d", i), W'(hi), (i % 3 == 0) ? 1 : 0);
    end

    // Square wave, channel 2, reload 1.
    wr(2'b11, 32'h20);
    wr(2'b10, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick(2, hi);
      rd(2'b10, v);
      check($sformatf("sq_cnt_t%0d", i), v, (i % 2 == 1) ? 0 : 1);
      check($sformatf("sq_out_t%0d", i), {31'b0, counter2_OUT}, W'((i / 2) % 2));
    end

    // Halt on channel 0: count frozen.
    wr(2'b11, 32'h23);
    wr(2'b00, 32'd5);
    for (int i = 1; i <= 3; i++) begin
      tick(0, hi);
      rd(2'b00, v);
      check($sformatf("halt_cnt_t%0d", i), v, 5);
    end

    // Back to one-shot. Bits above 5 of the control word are dropped.
    wr(2'b11, 32'hFFFF_FFE0);
    rd(2'b11, v); check("ctrl_mask_rd", v, 32'h20);

    // Write coinciding with the tick0 that it must swallow.
    @(negedge clk);
    clk0 = 1'b1;
`ifdef COUNTER_X_SYNC_EN
    repeat (2) @(negedge clk);
`endif
    counter_we = 1'b1; counter_ch = 2'b00; counter_val = 32'd7;
    @(negedge clk);
    counter_we = 1'b0;
    repeat (4) @(negedge clk);
    clk0 = 1'b0;
    repeat (2) @(negedge clk);
    rd(2'b00, v); check("collide_cnt", v, 7);
    tick(0, hi);
    rd(2'b00, v); check("after_collide_cnt", v, 6);

    // Reload 0 in one-shot mode: the first tick sets OUT.
    wr(2'b00, 32'd0);
    check("zero_out_clr", {31'b0, counter0_OUT}, 0);
    tick(0, hi);
    check("zero_out_set", {31'b0, counter0_OUT}, 1);
    rd(2'b00, v); check("zero_cnt", v, 0);

    // Async reset mid-count: channel 2 square wave reload 4, 5 ticks.
    wr(2'b10, 32'd4);
    for (int i = 0; i < 5; i++) tick(2, hi);
    rd(2'b10, v); check("pre_rst_cnt2", v, 4);
    check("pre_rst_out2", {31'b0, counter2_OUT}, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_out2", {31'b0, counter2_OUT}, 0);
    check("arst_cnt2", counter_out, 0);
    counter_ch = 2'b11;
    #1;
    check("arst_ctrl", counter_out, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_x.md
Name: counter_x

Overview:
- Three-channel, 8253-style programmable down-counter peripheral on the MIO bus.
- The CPU writes reload values and a control word through one write port (channel select + strobe). The CPU reads back the selected count.
- Each channel decrements on rising edges of its own slow tick input, taken from the clock divider taps. It drives one output; counter0's output is the CPU interrupt source.
- Everything runs in a single clock domain. Tick inputs are edge-detected, never used as clocks.

Parameters:
- CNT_W, 32, width of each counter, reload register and data bus.
- RST_MODE, 2'b00, mode loaded into every channel's control field at reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- clk0  in  1  tick source for channel 0 (divider tap); level signal, asynchronous to clk.
- clk1  in  1  tick source for channel 1.
- clk2  in  1  tick source for channel 2.
- counter_we  in  1  write strobe, one clk cycle per write.
- counter_val  in  CNT_W  write data.
- counter_ch  in  2  channel select: 00/01/10 = counter 0/1/2, 11 = control word.
- counter0_OUT  in→out  1  channel 0 output (this is an output).
- counter1_OUT  out  1  channel 1 output.
- counter2_OUT  out  1  channel 2 output.
- counter_out  out  CNT_W  readback: count of the selected channel; for ch=11, control word zero-extended.

Behaviour:
- Reset (rstn=0, async):
  - counts = 0, reload registers = 0, OUT0..2 = 0.
  - Control fields = RST_MODE. With the default 00 this is one-shot.
  - Synchronizer/edge flops = 0.
- Control word bits [2n+1:2n] set the mode of channel n; bits above 5 are ignored and read back as 0:
  - 00 one-shot.
  - 01 rate generator (auto-reload, 1-cycle pulse).
  - 10 square wave (auto-reload, toggle).
  - 11 halt: count frozen, OUT held.
- Write, counter_we=1 at a clk edge:
  - ch 0..2: reload[n] <= counter_val and count[n] <= counter_val. OUT[n] <= 0.
  - ch 11: control[5:0] <= counter_val[5:0]. Counts and outputs are untouched.
- Tick detection: each clkN passes through the synchronizer (see Optional Feature). tickN = 1 for exactly one clk cycle per rising edge of clkN. Falling edges are ignored.
- On tickN, with channel not halted and not being written this cycle:
  - count != 0: count <= count − 1. Mode 01 clears OUT to 0. Other modes keep OUT.
  - count == 0, mode 00: OUT <= 1 and stays 1. Count stays 0. Further ticks do nothing until the next write.
  - count == 0, mode 01: count <= reload. OUT <= 1 for this one clk cycle; it clears on the next clk edge unless another terminal tick occurs.
  - count == 0, mode 10: count <= reload. OUT <= ~OUT.
- Reload value 0:
  - Mode 00: the first tick sets OUT.
  - Mode 01/10: fires on every tick.
- A write to channel n in the same cycle as tickN: the write wins and the tick is lost.
- A control write in the same cycle as a tick: the tick is processed under the old mode. The new mode takes effect next cycle.
- counter_out is combinational from counter_ch and the registers. A write is visible on the next cycle.
- Arithmetic is unsigned modulo 2^CNT_W. No decrement ever occurs from 0; the terminal-count rules above apply instead.
- Reset asserted mid-count: immediate return to reset values. Pending ticks are discarded.

Optional Feature:
- COUNTER_X_SYNC_EN defined:
  - clkN goes through a 2-flop synchronizer, then an edge flop.
  - tickN is high in the 3rd clk cycle after clkN rises (setup-met). The count updates at the end of that cycle.
- Not defined:
  - Single edge flop only; clkN is assumed synchronous to clk.
  - tickN is high in the 1st cycle after the rising edge is sampled, i.e. 2 cycles less latency.
- Functional results are otherwise identical.

Test Plan:
- Reset: hold rstn=0, toggle clk0..2 and pulse counter_we → all outputs 0, counter_out=0 for every ch, control readback 0.
- One-shot: write ch=00 val=3, then 4 clk0 rising edges → count reads 2,1,0,0. counter0_OUT goes 1 on the 4th tick and stays 1 through 3 more ticks.
- Rate generator: write ch=11 val=0x04 (ch1 mode 01), ch=01 val=2, 9 clk1 edges → counter1_OUT is a 1-clk pulse on ticks 3, 6 and 9. Count sequence 1,0,2,1,0,2.
- Square wave: ch=11 val=0x20 (ch2 mode 10), ch=10 val=1, 8 clk2 edges → counter2_OUT toggles every 2nd tick (0→1 on tick 2, 1→0 on tick 4…).
- Halt/collision: channel 0 mode 11, val=5, 3 ticks → count stays 5. Then mode 00 with a write of val=7 coinciding with tick0 → count reads 7, not 6.
- Async reset mid-count: assert rstn=0 between clk edges with count=4 and OUT2=1 → count and OUT clear immediately, before the next clk edge.
